seg_display_sched: RTL and testbench



---
 rtl/seg_display_sched.sv | 244 ++++++++++++++++++++++++
 tb/tb_seg_display_sched.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_sched.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_sched
//  Description : Time-slices one 8-digit seven-segment display bank between
//                N_REQ requesters. Each valid requester holds the display for
//                DWELL cycles in round-robin order. The block also provides a
//                hold control, a manual force-select override and blinking of
//                the status digits while the shown requester reports an error.
//
//  Ports       : clk         system clock
//                rst         synchronous active-high reset
//                req_valid   [N_REQ]     requester i wants display time
//                req_value   [16*N_REQ]  16-bit value of requester i
//                req_status  [2*N_REQ]   0 idle, 1 run, 2 done, 3 err
//                hold        freeze the slot timer
//                force_en    override round-robin with force_id
//                force_id    [4]         requester shown while forced
//                digit_code  [40]        digit k code at [5k+4:5k], digit 7 leftmost
//                cur_id      [4]         requester currently shown
//                cur_valid   a requester is currently shown
//                slot_tick   one-cycle pulse on a dwell-expiry switch
//
//  Revision    : 1.0  initial release
// ============================================================================
module seg_display_sched #(
    parameter int N_REQ      = 4,
    parameter int DWELL      = 50000000,
    parameter int BLINK_HALF = 12500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [16*N_REQ-1:0]  req_value,
    input  logic [2*N_REQ-1:0]   req_status,
    input  logic                 hold,
    input  logic                 force_en,
    input  logic [3:0]           force_id,
    output logic [39:0]          digit_code,
    output logic [3:0]           cur_id,
    output logic                 cur_valid,
    output logic                 slot_tick
);

    localparam int c_DW = $clog2(DWELL);
    localparam int c_BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(DWELL - 1);
    localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_HALF - 1);
    localparam logic [4:0]      c_NREQ5      = 5'(N_REQ);

    // Digit decoder codes
    localparam logic [4:0] c_E   = 5'd14;
    localparam logic [4:0] c_D   = 5'd13;
    localparam logic [4:0] c_N   = 5'd19;
    localparam logic [4:0] c_R   = 5'd22;
    localparam logic [4:0] c_U   = 5'd25;
    localparam logic [4:0] c_O   = 5'd20;
    localparam logic [4:0] c_F   = 5'd15;
    localparam logic [4:0] c_OFF = 5'd27;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t             r_state, w_state_n;
    logic [3:0]         r_cur_id, w_id_n;
    logic [c_DW-1:0]    r_cnt, w_cnt_n;
    logic [c_BW-1:0]    r_bcnt, w_bcnt_n;
    logic               r_phase, w_phase_n;
    logic               r_force_q;
    logic               r_valid, r_tick, w_tick_n;
    logic [39:0]        r_digit;

    // ------------------------------------------------------------------------
    // Requester inputs widened to 16 entries so a 4-bit id can index them
    // directly; unused entries read as invalid / zero.
    // ------------------------------------------------------------------------
    logic [15:0] w_val [16];
    logic [1:0]  w_sts [16];
    logic [15:0] w_valid16;

    for (genvar gi = 0; gi < 16; gi++) begin : g_unpack
        if (gi < N_REQ) begin : g_used
            assign w_val[gi]     = req_value[16*gi +: 16];
            assign w_sts[gi]     = req_status[2*gi +: 2];
            assign w_valid16[gi] = req_valid[gi];
        end else begin : g_unused
            assign w_val[gi]     = 16'h0000;
            assign w_sts[gi]     = 2'd0;
            assign w_valid16[gi] = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin search. next(cur) is the lowest valid index above cur, or,
    // failing that, the lowest valid index overall (which may be cur itself).
    // An out-of-range cur simply falls through to the lowest valid index.
    // ------------------------------------------------------------------------
    logic [3:0] w_first, w_after, w_next;
    logic       w_found_after, w_any, w_cur_vld;

    always_comb begin
        w_first       = 4'd0;
        w_after       = 4'd0;
        w_found_after = 1'b0;
        for (int j = 15; j >= 0; j--) begin
            if (w_valid16[j]) begin
                w_first = 4'(j);
                if (4'(j) > r_cur_id) begin
                    w_after       = 4'(j);
                    w_found_after = 1'b1;
                end
            end
        end
        w_next    = w_found_after ? w_after : w_first;
        w_any     = |req_valid;
        w_cur_vld = w_valid16[r_cur_id];
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_n = r_state;
        w_id_n    = r_cur_id;
        w_cnt_n   = r_cnt;
        w_tick_n  = 1'b0;
        case (r_state)
            ST_BLANK: begin
                w_cnt_n = '0;
                if (force_en) begin
                    w_state_n = ST_SHOW;
                    w_id_n    = force_id;
                end else if (w_any) begin
                    w_state_n = ST_SHOW;
                    w_id_n    = w_first;
                end
            end
            ST_SHOW: begin
                if (force_en) begin
                    w_id_n  = force_id;
                    w_cnt_n = '0;
                end else if (r_force_q || !w_cur_vld) begin
                    // Leaving force, or the shown requester went away: keep the
                    // current id if it is still valid, else move on. No tick.
                    w_cnt_n = '0;
                    if (!w_cur_vld) begin
                        if (w_any) begin
                            w_id_n = w_next;
                        end else begin
                            w_state_n = ST_BLANK;
                            w_id_n    = 4'd0;
                        end
                    end
                end else if (hold) begin
                    w_cnt_n = r_cnt;
                end else if (r_cnt == c_DWELL_LAST) begin
                    w_id_n   = w_next;
                    w_cnt_n  = '0;
                    w_tick_n = 1'b1;
                end else begin
                    w_cnt_n = r_cnt + c_DW'(1);
                end
            end
            default: begin
                w_state_n = ST_BLANK;
                w_id_n    = 4'd0;
                w_cnt_n   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Blink timer and display image for the state being entered
    // ------------------------------------------------------------------------
    logic           w_blast, w_show_n;
    logic [1:0]     w_sts_n;
    logic [15:0]    w_val_n;
    logic [7:0][4:0] w_dig;

    always_comb begin
        w_blast   = (r_bcnt == c_BLINK_LAST);
        w_bcnt_n  = w_blast ? '0 : r_bcnt + c_BW'(1);
        w_phase_n = w_blast ? ~r_phase : r_phase;

        w_show_n  = (w_state_n == ST_SHOW) && ({1'b0, w_id_n} < c_NREQ5);
        w_sts_n   = w_sts[w_id_n];
        w_val_n   = w_val[w_id_n];

        w_dig = {8{c_OFF}};
        if (w_show_n) begin
            case (w_sts_n)
                2'd0:    begin w_dig[7] = c_O; w_dig[6] = c_F; w_dig[5] = c_F; end
                2'd1:    begin w_dig[7] = c_R; w_dig[6] = c_U; w_dig[5] = c_N; end
                2'd2:    begin w_dig[7] = c_E; w_dig[6] = c_N; w_dig[5] = c_D; end
                default: begin w_dig[7] = c_E; w_dig[6] = c_R; w_dig[5] = c_R; end
            endcase
            if (w_sts_n == 2'd3 && w_phase_n) begin
                w_dig[7] = c_OFF;
                w_dig[6] = c_OFF;
                w_dig[5] = c_OFF;
            end
            w_dig[4] = {1'b0, w_id_n};
            w_dig[3] = {1'b0, w_val_n[15:12]};
            w_dig[2] = {1'b0, w_val_n[11:8]};
            w_dig[1] = {1'b0, w_val_n[7:4]};
            w_dig[0] = {1'b0, w_val_n[3:0]};
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_BLANK;
            r_cur_id  <= 4'd0;
            r_cnt     <= '0;
            r_bcnt    <= '0;
            r_phase   <= 1'b0;
            r_force_q <= 1'b0;
            r_valid   <= 1'b0;
            r_tick    <= 1'b0;
            r_digit   <= {8{c_OFF}};
        end else begin
            r_state   <= w_state_n;
            r_cur_id  <= w_id_n;
            r_cnt     <= w_cnt_n;
            r_bcnt    <= w_bcnt_n;
            r_phase   <= w_phase_n;
            r_force_q <= force_en;
            r_valid   <= w_show_n;
            r_tick    <= w_tick_n;
            r_digit   <= w_dig;
        end
    end

    assign digit_code = r_digit;
    assign cur_id     = r_cur_id;
    assign cur_valid  = r_valid;
    assign slot_tick  = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_display_sched
//  Description : Directed self-checking bench for seg_display_sched with
//                N_REQ=4, DWELL=8, BLINK_HALF=4.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg_display_sched;

    localparam int N_REQ      = 4;
    localparam int DWELL      = 8;
    localparam int BLINK_HALF = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_value;
    logic [7:0]  req_status;
    logic        hold;
    logic        force_en;
    logic [3:0]  force_id;
    logic [39:0] digit_code;
    logic [3:0]  cur_id;
    logic        cur_valid;
    logic        slot_tick;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seg_display_sched #(
        .N_REQ      (N_REQ),
        .DWELL      (DWELL),
        .BLINK_HALF (BLINK_HALF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_value  (req_value),
        .req_status (req_status),
        .hold       (hold),
        .force_en   (force_en),
        .force_id   (force_id),
        .digit_code (digit_code),
        .cur_id     (cur_id),
        .cur_valid  (cur_valid),
        .slot_tick  (slot_tick)
    );

    function automatic logic [39:0] pk(input int d7, input int d6, input int d5, input int d4,
                                       input int d3, input int d2, input int d1, input int d0);
        return {5'(d7), 5'(d6), 5'(d5), 5'(d4), 5'(d3), 5'(d2), 5'(d1), 5'(d0)};
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [39:0] c_blank, c_run0, c_end2, c_err1_on, c_err1_off, c_end3;

    initial begin
        c_blank    = {8{5'd27}};
        c_run0     = pk(22, 25, 19, 0, 1, 2, 10, 11);
        c_end2     = pk(14, 19, 13, 2, 0, 0, 15, 0);
        c_err1_on  = pk(14, 22, 22, 1, 11, 14, 14, 15);
        c_err1_off = pk(27, 27, 27, 1, 11, 14, 14, 15);
        c_end3     = pk(14, 19, 13, 3, 3, 12, 5, 10);

        // ---- 1. reset with arbitrary inputs
        rst        = 1'b1;
        req_valid  = 4'b1111;
        req_value  = 64'h1234_5678_9ABC_DEF0;
        req_status = 8'hFF;
        hold       = 1'b1;
        force_en   = 1'b1;
        force_id   = 4'd2;
        step();
        step();
        chk("rst_digits", digit_code, c_blank);
        chk("rst_valid",  cur_valid,  1'b0);
        chk("rst_tick",   slot_tick,  1'b0);
        chk("rst_id",     cur_id,     4'd0);

        // ---- 2. two requesters round-robin
        req_valid  = 4'b0101;
        req_value  = 64'h0000_00F0_0000_12AB;
        req_status = 8'h21;
        hold       = 1'b0;
        force_en   = 1'b0;
        force_id   = 4'd0;
        rst        = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_slot0_digits", digit_code, c_run0);
            chk("rr_slot0_tick",   slot_tick,  1'b0);
        end
        chk("rr_slot0_valid", cur_valid, 1'b1);
        step();
        chk("rr_sw1_tick",   slot_tick,  1'b1);
        chk("rr_sw1_digits", digit_code, c_end2);
        chk("rr_sw1_id",     cur_id,     4'd2);
        for (int k = 0; k < 7; k++) begin
            step();
            chk("rr_slot2_digits", digit_code, c_end2);
            chk("rr_slot2_tick",   slot_tick,  1'b0);
        end
        step();
        chk("rr_sw2_tick", slot_tick, 1'b1);
        chk("rr_sw2_id",   cur_id,    4'd0);

        // ---- 3. drop requester 0 at cycle 3 of its slot
        step();
        step();
        step();
        req_valid = 4'b0100;
        step();
        chk("drop_id",     cur_id,     4'd2);
        chk("drop_tick",   slot_tick,  1'b0);
        chk("drop_digits", digit_code, c_end2);
        for (int k = 0; k < 7; k++) begin
            step();
            chk("drop_run_tick", slot_tick, 1'b0);
            chk("drop_run_id",   cur_id,    4'd2);
        end
        step();
        chk("drop_resel_tick", slot_tick, 1'b1);
        chk("drop_resel_id",   cur_id,    4'd2);

        // ---- 4. hold for 20 cycles mid-slot
        req_valid = 4'b0101;
        step();
        step();
        step();
        hold = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("hold_tick", slot_tick, 1'b0);
            chk("hold_id",   cur_id,    4'd2);
        end
        hold = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("unhold_tick", slot_tick, 1'b0);
            chk("unhold_id",   cur_id,    4'd2);
        end
        step();
        chk("unhold_sw_tick",   slot_tick,  1'b1);
        chk("unhold_sw_id",     cur_id,     4'd0);
        chk("unhold_sw_digits", digit_code, c_run0);

        // ---- mid-slot reset wins over hold and force
        step();
        rst      = 1'b1;
        hold     = 1'b1;
        force_en = 1'b1;
        force_id = 4'd2;
        step();
        chk("midrst_digits", digit_code, c_blank);
        chk("midrst_valid",  cur_valid,  1'b0);
        chk("midrst_id",     cur_id,     4'd0);
        step();

        // ---- 5. single err requester, blink
        hold       = 1'b0;
        force_en   = 1'b0;
        force_id   = 4'd0;
        req_valid  = 4'b0010;
        req_value  = 64'h0000_0000_BEEF_0000;
        req_status = 8'h0C;
        rst        = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("blink_digits", digit_code, (((k / 4) % 2) == 1) ? c_err1_off : c_err1_on);
            chk("blink_tick",   slot_tick,  (k == 9 || k == 17) ? 1'b1 : 1'b0);
            chk("blink_id",     cur_id,     4'd1);
        end

        // ---- 6. force an invalid requester, then release
        req_valid  = 4'b0001;
        req_value  = 64'h3C5A_0000_0000_12AB;
        req_status = 8'h81;
        force_en   = 1'b1;
        force_id   = 4'd3;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("force_digits", digit_code, c_end3);
            chk("force_tick",   slot_tick,  1'b0);
            chk("force_id",     cur_id,     4'd3);
            chk("force_valid",  cur_valid,  1'b1);
        end
        force_en = 1'b0;
        step();
        chk("unforce_id",     cur_id,     4'd0);
        chk("unforce_digits", digit_code, c_run0);
        chk("unforce_tick",   slot_tick,  1'b0);
        for (int k = 0; k < 7; k++) begin
            step();
            chk("unforce_run_tick", slot_tick, 1'b0);
        end
        step();
        chk("unforce_sw_tick", slot_tick, 1'b1);
        chk("unforce_sw_id",   cur_id,    4'd0);

        // ---- force an out-of-range id
        force_en = 1'b1;
        force_id = 4'd5;
        step();
        chk("oor_digits", digit_code, c_blank);
        chk("oor_valid",  cur_valid,  1'b0);
        chk("oor_id",     cur_id,     4'd5);
        force_en = 1'b0;
        step();
        chk("oor_rel_id",    cur_id,    4'd0);
        chk("oor_rel_valid", cur_valid, 1'b1);

        // ---- everything withdrawn -> blank
        req_valid = 4'b0000;
        step();
        chk("none_digits", digit_code, c_blank);
        chk("none_valid",  cur_valid,  1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
